// File: rtl/flght_cntrl_pkg.sv
// Shared constants and helpers for the quadcopter attitude controller.
// Speed values are 13-bit two's complement until clamped to 11-bit motor commands.
package flght_cntrl_pkg;

    localparam int unsigned D_QUEUE_DEPTH = 12;
    localparam int unsigned ERR_W         = 10;
    localparam int unsigned DIFF_W        = 7;
    localparam int unsigned SPD_W         = 11;

    localparam logic [12:0]       MIN_RUN_SPEED = 13'h2C0;
    localparam logic [SPD_W-1:0]  CAL_SPEED     = 11'h1B0;
    localparam logic signed [4:0] DTERM         = 5'sd7;

    // Clamp a signed 13-bit mix result to an unsigned 11-bit motor speed.
    function automatic logic [SPD_W-1:0] sat_spd(input logic [12:0] mix);
        if (mix[12]) begin
            sat_spd = '0;
        end else if (mix[11]) begin
            sat_spd = '1;
        end else begin
            sat_spd = mix[SPD_W-1:0];
        end
    endfunction

endpackage

// File: rtl/flght_cntrl_pd_math.sv
// Per-axis PD term: saturated error, proportional term and a derivative against
// the oldest entry of a vld-advanced history queue.
module pd_math
    import flght_cntrl_pkg::*;
#(
    parameter int unsigned Depth = D_QUEUE_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vld,
    input  logic [15:0] desired,
    input  logic [15:0] actual,
    output logic [9:0]  pterm,
    output logic [11:0] dterm
);

    logic signed [15:0]       err;
    logic signed [ERR_W-1:0]  err_sat;
    logic signed [ERR_W:0]    d_diff;
    logic signed [DIFF_W-1:0] d_diff_sat;
    logic signed [11:0]       d_ext;
    logic signed [11:0]       gain_ext;
    logic [ERR_W-1:0]         queue_q [Depth];
    logic [ERR_W-1:0]         queue_d [Depth];

    always_comb begin
        err = $signed(actual - desired);
        if (err > 16'sd511) begin
            err_sat = 10'sd511;
        end else if (err < -16'sd512) begin
            err_sat = -10'sd512;
        end else begin
            err_sat = err[ERR_W-1:0];
        end

        pterm = (err_sat >>> 1) + (err_sat >>> 3);

        d_diff = {err_sat[ERR_W-1], err_sat} - {queue_q[Depth-1][ERR_W-1], queue_q[Depth-1]};
        if (d_diff > 11'sd63) begin
            d_diff_sat = 7'sd63;
        end else if (d_diff < -11'sd64) begin
            d_diff_sat = -7'sd64;
        end else begin
            d_diff_sat = d_diff[DIFF_W-1:0];
        end

        d_ext    = {{5{d_diff_sat[DIFF_W-1]}}, d_diff_sat};
        gain_ext = {{7{DTERM[4]}}, DTERM};
        dterm    = d_ext * gain_ext;
    end

    always_comb begin
        queue_d = queue_q;
        if (vld) begin
            queue_d[0] = err_sat;
            for (int i = 1; i < Depth; i++) begin
                queue_d[i] = queue_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            queue_q <= '{default: '0};
        end else begin
            queue_q <= queue_d;
        end
    end

endmodule

// File: rtl/flght_cntrl.sv
// Quadcopter attitude controller: three PD axes mixed with thrust into four
// registered, saturated motor speeds; calibration forces a fixed speed.
module flght_cntrl
    import flght_cntrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vld,
    input  logic             inertial_cal,
    input  logic [15:0]      d_ptch,
    input  logic [15:0]      d_roll,
    input  logic [15:0]      d_yaw,
    input  logic [15:0]      ptch,
    input  logic [15:0]      roll,
    input  logic [15:0]      yaw,
    input  logic [8:0]       thrst,
    output logic [SPD_W-1:0] frnt_spd,
    output logic [SPD_W-1:0] bck_spd,
    output logic [SPD_W-1:0] lft_spd,
    output logic [SPD_W-1:0] rght_spd
);

    logic [9:0]       ptch_p, roll_p, yaw_p;
    logic [11:0]      ptch_d, roll_d, yaw_d;
    logic [12:0]      p_ptch, p_roll, p_yaw, base;
    logic [SPD_W-1:0] frnt_d, bck_d, lft_d, rght_d;
    logic [SPD_W-1:0] frnt_q, bck_q, lft_q, rght_q;

    pd_math u_pd_ptch (
        .clk     (clk),
        .rst_n   (rst_n),
        .vld     (vld),
        .desired (d_ptch),
        .actual  (ptch),
        .pterm   (ptch_p),
        .dterm   (ptch_d)
    );

    pd_math u_pd_roll (
        .clk     (clk),
        .rst_n   (rst_n),
        .vld     (vld),
        .desired (d_roll),
        .actual  (roll),
        .pterm   (roll_p),
        .dterm   (roll_d)
    );

    pd_math u_pd_yaw (
        .clk     (clk),
        .rst_n   (rst_n),
        .vld     (vld),
        .desired (d_yaw),
        .actual  (yaw),
        .pterm   (yaw_p),
        .dterm   (yaw_d)
    );

    always_comb begin
        p_ptch = {{3{ptch_p[9]}}, ptch_p} + {ptch_d[11], ptch_d};
        p_roll = {{3{roll_p[9]}}, roll_p} + {roll_d[11], roll_d};
        p_yaw  = {{3{yaw_p[9]}}, yaw_p} + {yaw_d[11], yaw_d};
        base   = MIN_RUN_SPEED + {4'b0, thrst};

        if (inertial_cal) begin
            frnt_d = CAL_SPEED;
            bck_d  = CAL_SPEED;
            lft_d  = CAL_SPEED;
            rght_d = CAL_SPEED;
        end else begin
            frnt_d = sat_spd(base - p_ptch - p_yaw);
            bck_d  = sat_spd(base + p_ptch - p_yaw);
            lft_d  = sat_spd(base - p_roll + p_yaw);
            rght_d = sat_spd(base + p_roll + p_yaw);
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            frnt_q <= '0;
            bck_q  <= '0;
            lft_q  <= '0;
            rght_q <= '0;
        end else begin
            frnt_q <= frnt_d;
            bck_q  <= bck_d;
            lft_q  <= lft_d;
            rght_q <= rght_d;
        end
    end

    assign frnt_spd = frnt_q;
    assign bck_spd  = bck_q;
    assign lft_spd  = lft_q;
    assign rght_spd = rght_q;

endmodule

// File: tb/tb_flght_cntrl.sv
// Directed-vector bench for flght_cntrl with hand-computed expected motor speeds.
module tb_flght_cntrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vld;
    logic        inertial_cal;
    logic [15:0] d_ptch, d_roll, d_yaw, ptch, roll, yaw;
    logic [8:0]  thrst;
    logic [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;

    int vectors     = 0;
    int miscompares = 0;

    flght_cntrl u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vld          (vld),
        .inertial_cal (inertial_cal),
        .d_ptch       (d_ptch),
        .d_roll       (d_roll),
        .d_yaw        (d_yaw),
        .ptch         (ptch),
        .roll         (roll),
        .yaw          (yaw),
        .thrst        (thrst),
        .frnt_spd     (frnt_spd),
        .bck_spd      (bck_spd),
        .lft_spd      (lft_spd),
        .rght_spd     (rght_spd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check4(input string tag, input logic [10:0] ef, input logic [10:0] eb,
                          input logic [10:0] el, input logic [10:0] er);
        check({tag, ".frnt"}, frnt_spd, ef);
        check({tag, ".bck"},  bck_spd,  eb);
        check({tag, ".lft"},  lft_spd,  el);
        check({tag, ".rght"}, rght_spd, er);
    endtask

    // Pulse reset mid-cycle with all inputs zeroed; queues come back empty.
    task automatic do_reset();
        rst_n = 1'b1;
        {vld, inertial_cal, thrst} = '0;
        {d_ptch, d_roll, d_yaw, ptch, roll, yaw} = '0;
        tick();
        rst_n = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        {vld, inertial_cal, thrst} = '0;
        {d_ptch, d_roll, d_yaw, ptch, roll, yaw} = '0;
        #1;
        check4("reset", 11'h000, 11'h000, 11'h000, 11'h000);
        tick();
        check4("reset_held", 11'h000, 11'h000, 11'h000, 11'h000);
        rst_n = 1'b0;
        tick();
        check4("idle", 11'h2C0, 11'h2C0, 11'h2C0, 11'h2C0);

        thrst = 9'h1FF;
        tick();
        check4("thrust", 11'h4BF, 11'h4BF, 11'h4BF, 11'h4BF);

        inertial_cal = 1'b1;
        ptch         = 16'h0123;
        tick();
        check4("cal", 11'h1B0, 11'h1B0, 11'h1B0, 11'h1B0);
        inertial_cal = 1'b0;
        ptch         = 16'h0000;
        tick();
        check4("cal_release", 11'h4BF, 11'h4BF, 11'h4BF, 11'h4BF);

        // Pitch step on an empty queue, then let the queue fill with the step.
        do_reset();
        ptch = 16'h0100;
        vld  = 1'b1;
        tick();
        check4("ptch_step", 11'h067, 11'h519, 11'h2C0, 11'h2C0);
        for (int i = 0; i < 11; i++) tick();
        check4("ptch_q11", 11'h067, 11'h519, 11'h2C0, 11'h2C0);
        tick();
        check4("ptch_qfull", 11'h220, 11'h360, 11'h2C0, 11'h2C0);

        // Asynchronous reset takes effect without a clock edge.
        rst_n = 1'b1;
        #1;
        check4("async_rst", 11'h000, 11'h000, 11'h000, 11'h000);
        tick();
        rst_n = 1'b0;
        {vld, ptch} = '0;

        // vld held low after one step: D term frozen at the step value.
        do_reset();
        ptch = 16'h0100;
        vld  = 1'b1;
        tick();
        vld = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check4("vld_hold", 11'h067, 11'h519, 11'h2C0, 11'h2C0);

        do_reset();
        roll = 16'h0100;
        tick();
        check4("roll_step", 11'h2C0, 11'h2C0, 11'h067, 11'h519);

        do_reset();
        yaw = 16'hC000;
        tick();
        check4("yaw_sat", 11'h5C0, 11'h5C0, 11'h000, 11'h000);

        do_reset();
        yaw   = 16'hC000;
        ptch  = 16'hC000;
        thrst = 9'h1FF;
        tick();
        check4("overflow", 11'h7FF, 11'h4BF, 11'h1BF, 11'h1BF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/flght_cntrl.md
Name: flght_cntrl

Overview:
- Quadcopter attitude controller.
- Forms pitch, roll and yaw errors (measured minus desired) and runs a proportional-derivative (PD) term on each.
- Mixes the PD terms with thrust into four motor speed commands, each registered and saturated to 11 bits.
- Sits between the inertial/command interface and the ESC interface; during inertial calibration it drives a fixed calibration speed.

Parameters:
- D_QUEUE_DEPTH, 12: number of past saturated errors held per axis for the derivative term.
- MIN_RUN_SPEED, 13'h2C0: base motor speed added to every output.
- CAL_SPEED, 11'h1B0: speed driven on all motors while inertial_cal=1.
- DTERM, 5'sd7: signed derivative gain.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-high reset (asserted when 1).
- vld  in  1  new attitude sample valid; advances the derivative queues.
- inertial_cal  in  1  calibration mode; forces CAL_SPEED on all motors.
- d_ptch, d_roll, d_yaw  in  16 each  desired attitude, signed.
- ptch, roll, yaw  in  16 each  measured attitude, signed.
- thrst  in  9  thrust, unsigned.
- frnt_spd, bck_spd, lft_spd, rght_spd  out  11 each  motor speeds, unsigned, registered.

Behaviour:
- Reset (rst_n=1, asynchronous): all four speed registers go to 0; all queue entries go to 0.
- Per-axis error: err = measured - desired, 16-bit signed.
  - err_sat saturates err to 10-bit signed: above 511 gives 511, below -512 gives -512.
- P term: p = (err_sat>>>1) + (err_sat>>>3), using arithmetic shifts.
- D term:
  - d_diff = err_sat - q[D_QUEUE_DEPTH-1], using the registered queue contents of the current cycle.
  - d_diff saturates to 7-bit signed (-64..63).
  - d = d_diff_sat * DTERM, signed, 12 bits.
- Queue update: on a clock edge with vld=1, each queue shifts by one, q[0] takes the current err_sat and the oldest entry drops. When vld=0 the queue holds.
- Mixing: all terms sign-extended to 13 bits; thrst zero-extended. With P = pterm + dterm for each axis:
  - frnt = MIN_RUN_SPEED + thrst - P_ptch - P_yaw
  - bck = MIN_RUN_SPEED + thrst + P_ptch - P_yaw
  - lft = MIN_RUN_SPEED + thrst - P_roll + P_yaw
  - rght = MIN_RUN_SPEED + thrst + P_roll + P_yaw
- Output saturation: negative gives 0; greater than 0x7FF gives 0x7FF; otherwise the low 11 bits.
- Output select: if inertial_cal=1 the registered value is CAL_SPEED on all four motors; otherwise the saturated mix.
- Latency: inputs are combinational to the output registers, so outputs reflect inputs sampled at the previous rising edge (one cycle).
- inertial_cal does not block queue updates; vld still shifts the queues during calibration.
- Reset asserted mid-operation clears everything immediately. The first cycle after reset sees an all-zero queue, so d_diff equals err_sat.

Decomposition:
- Package flght_cntrl_pkg holds MIN_RUN_SPEED, CAL_SPEED, DTERM, D_QUEUE_DEPTH defaults and the saturation widths (10, 7, 11).
- Sub-module pd_math (clk, rst_n, vld, desired, actual, outputs pterm[9:0] and dterm[11:0]) contains the error, saturation and queue logic; it is instantiated three times.
- The top level holds the mixing, saturation and output registers.

Test Plan:
- Reset and zero inputs: rst_n=1 then 0, all attitudes 0, thrst=0, inertial_cal=0 → all speeds 0 during reset, then 0x2C0 after one clock.
- Thrust only: thrst=0x1FF, zero errors → all speeds 0x4BF.
- Calibration: inertial_cal=1 with any inputs → all speeds 0x1B0 one clock later; releasing it returns to the mixed values.
- Pitch step just after reset: ptch=0x0100, vld=1, queue empty (d_diff saturates to 63) → frnt=0x067, bck=0x519, lft=rght=0x2C0.
  - After 12 more vld cycles with the step held (queue full of 256): frnt=0x220, bck=0x360.
- Yaw saturation: yaw=0xC000, queue empty → frnt=bck=0x5C0, lft=rght=0 (underflow clamp).
- vld hold: with vld=0 for many cycles after the step, the D term stays at its step value and outputs stay frozen.
